// File: rtl/matmul_entry_engine.sv
// Dot-product datapath for the matmul controller: walks an 8-entry A/B buffer, product registered 1 cycle after issue, summed the next.
// No backpressure: host writes outside IDLE/HOLD are dropped with a wr_drop pulse; controller protocol slips set a sticky seq_error.
module matmul_entry_engine #(
  parameter int DATA_W    = 8,
  parameter int N_ENTRIES = 8,
  parameter int ACC_W     = 2*DATA_W+3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic              multiply_matrix,
  input  logic              load_matrix,
  input  logic              add,
  input  logic              done,
  output logic [3:0]        entry_count,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              seq_error,
  output logic              wr_drop
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  typedef enum logic [1:0] {IDLE, RUN, SUM, HOLD} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem_a [N_ENTRIES];
  logic [DATA_W-1:0]   mem_b [N_ENTRIES];
  logic [IDX_W-1:0]    idx;
  logic                issued_all;
  logic [2*DATA_W-1:0] prod_q;
  logic                prod_v;
  logic [ACC_W-1:0]    partial;

  logic issue, load_result, set_err, set_valid, clr_valid, clr_run, wr_ok;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    load_result = 1'b0;
    set_err     = 1'b0;
    set_valid   = 1'b0;
    clr_valid   = 1'b0;
    wr_ok       = wr_en && (state == IDLE || state == HOLD);
    case (state)
      IDLE: begin
        if (done) set_err = 1'b1;
        if (multiply_matrix && load_matrix) begin
          issue     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (done) set_err = 1'b1;
        if (add) begin
          if (issued_all) begin
            load_result = 1'b1;
            state_nxt   = SUM;
          end else begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (!multiply_matrix) begin
          // Once every entry is issued the controller may idle before add.
          if (!issued_all) begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (load_matrix && !issued_all) begin
          issue = 1'b1;
        end
      end
      SUM: begin
        if (done) begin
          set_valid = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!done) begin
          clr_valid = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Clearing on entry keeps idx/partial at zero for the whole IDLE stay.
    clr_run = (state_nxt == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
      idx          <= '0;
      issued_all   <= 1'b0;
      prod_q       <= '0;
      prod_v       <= 1'b0;
      partial      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      seq_error    <= 1'b0;
      wr_drop      <= 1'b0;
    end else begin
      wr_drop <= wr_en && !wr_ok;
      if (wr_ok) begin
        mem_a[wr_addr] <= wr_a;
        mem_b[wr_addr] <= wr_b;
      end

      if (set_err) seq_error <= 1'b1;

      if (set_valid)      result_valid <= 1'b1;
      else if (clr_valid) result_valid <= 1'b0;

      if (load_result) result <= partial + (prod_v ? ACC_W'(prod_q) : '0);

      if (issue) begin
        prod_q <= mem_a[idx] * mem_b[idx];
        prod_v <= 1'b1;
        if (idx == IDX_W'(N_ENTRIES-1)) issued_all <= 1'b1;
        else                            idx        <= idx + 1'b1;
      end else begin
        prod_v <= 1'b0;
      end

      if (clr_run) begin
        idx        <= '0;
        issued_all <= 1'b0;
        prod_v     <= 1'b0;
        partial    <= '0;
      end else if (prod_v) begin
        partial <= partial + ACC_W'(prod_q);
      end
    end
  end

  assign entry_count = 4'(idx);
  assign busy        = (state == RUN) || (state == SUM);

endmodule

// File: tb/tb_matmul_entry_engine.sv
// Directed bench for matmul_entry_engine: controller sequences, host writes, reset abort and protocol errors.
module tb_matmul_entry_engine;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 19;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_a, wr_b;
  logic              multiply_matrix, load_matrix, add, done;
  logic [3:0]        entry_count;
  logic [ACC_W-1:0]  result;
  logic              result_valid, busy, seq_error, wr_drop;

  int vectors     = 0;
  int miscompares = 0;

  matmul_entry_engine #(.DATA_W(DATA_W), .N_ENTRIES(8), .ACC_W(ACC_W)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .multiply_matrix(multiply_matrix), .load_matrix(load_matrix),
    .add(add), .done(done),
    .entry_count(entry_count), .result(result), .result_valid(result_valid),
    .busy(busy), .seq_error(seq_error), .wr_drop(wr_drop)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input int addr, input int a, input int b);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_a    = 8'(a);
    wr_b    = 8'(b);
    tick();
    wr_en   = 1'b0;
  endtask

  // Multiply cycles first..first+n-1, checking the issued index each cycle.
  task automatic run_mul(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      multiply_matrix = 1'b1;
      load_matrix     = 1'b1;
      chk("entry_count", 32'(entry_count), 32'(k));
      tick();
      chk("busy_run", 32'(busy), 32'd1);
    end
    multiply_matrix = 1'b0;
    load_matrix     = 1'b0;
  endtask

  task automatic finish_run(input int exp);
    add = 1'b1;
    tick();
    add = 1'b0;
    chk("busy_sum", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    chk("result_valid_hold", 32'(result_valid), 32'd1);
    chk("result", 32'(result), 32'(exp));
    chk("busy_hold", 32'(busy), 32'd0);
  endtask

  task automatic drop_done(input int exp);
    done = 1'b0;
    tick();
    chk("result_valid_idle", 32'(result_valid), 32'd0);
    chk("result_retained", 32'(result), 32'(exp));
  endtask

  task automatic check_reset_outputs();
    chk("rst_entry_count", 32'(entry_count), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq_error", 32'(seq_error), 32'd0);
    chk("rst_wr_drop", 32'(wr_drop), 32'd0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    multiply_matrix = 1'b0; load_matrix = 1'b0; add = 1'b0; done = 1'b0;
    tick(); tick();
    check_reset_outputs();
    reset = 1'b0;

    // A[i]=i+1, B[i]=1 -> 36
    for (int i = 0; i < 8; i++) write_entry(i, i + 1, 1);
    run_mul(0, 8);
    finish_run(36);
    drop_done(36);

    // Maximal operands -> 8*255*255
    for (int i = 0; i < 8; i++) write_entry(i, 255, 255);
    run_mul(0, 8);
    finish_run(520200);
    drop_done(520200);

    // Reset during the 4th multiply cycle aborts everything
    run_mul(0, 3);
    multiply_matrix = 1'b1; load_matrix = 1'b1; reset = 1'b1;
    tick();
    check_reset_outputs();
    reset = 1'b0; multiply_matrix = 1'b0; load_matrix = 1'b0;
    for (int i = 0; i < 8; i++) write_entry(i, 2, 3);
    run_mul(0, 8);
    finish_run(48);
    drop_done(48);

    // Premature add after 5 multiplies
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_mul(0, 5);
    add = 1'b1;
    tick();
    add = 1'b0;
    chk("early_add_seq_error", 32'(seq_error), 32'd1);
    chk("early_add_result", 32'(result), 32'd0);
    chk("early_add_busy", 32'(busy), 32'd0);
    chk("early_add_entry_count", 32'(entry_count), 32'd0);
    for (int i = 0; i < 8; i++) write_entry(i, i + 1, 1);
    run_mul(0, 8);
    finish_run(36);
    chk("seq_error_sticky", 32'(seq_error), 32'd1);
    drop_done(36);

    // Host write during RUN is dropped
    run_mul(0, 2);
    multiply_matrix = 1'b1; load_matrix = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd3; wr_a = 8'd9; wr_b = 8'd1;
    chk("entry_count", 32'(entry_count), 32'd2);
    tick();
    wr_en = 1'b0;
    chk("wr_drop_pulse", 32'(wr_drop), 32'd1);
    run_mul(3, 1);
    chk("wr_drop_clear", 32'(wr_drop), 32'd0);
    run_mul(4, 4);
    finish_run(36);

    // Same write in HOLD is accepted
    write_entry(3, 9, 1);
    chk("hold_write_no_drop", 32'(wr_drop), 32'd0);
    drop_done(36);

    // Back-to-back runs with A[3]=9 -> 41 each
    run_mul(0, 8);
    finish_run(41);
    drop_done(41);
    run_mul(0, 8);
    finish_run(41);
    drop_done(41);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_entry_engine.md
Name: matmul_entry_engine

Overview:
- Datapath responder to the matrix-multiply controller FSM.
- Holds an 8-entry operand buffer (A and B vectors) written by the host.
- While the controller asserts multiply_matrix/load_matrix, it walks the buffer and drives entry_count back to the controller. It accumulates the A*B products, finalises the sum on add, and presents the result while done is high.

Parameters:
DATA_W, 8, operand width (unsigned)
N_ENTRIES, 8, entries per dot product; entry_count terminal value is N_ENTRIES-1 = 7
ACC_W, 19, accumulator/result width, 2*DATA_W+3; 8 maximal products cannot overflow

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  host operand write strobe
wr_addr  in  3  operand entry index
wr_a  in  DATA_W  A operand for entry wr_addr
wr_b  in  DATA_W  B operand for entry wr_addr
multiply_matrix  in  1  controller: multiply phase
load_matrix  in  1  controller: operand fetch enable
add  in  1  controller: accumulate/finalise cycle
done  in  1  controller: result store phase
entry_count  out  4  index of entry issued this cycle; registered; 0..7
result  out  ACC_W  dot-product sum
result_valid  out  1  result stable and valid
busy  out  1  high in RUN and SUM
seq_error  out  1  sticky controller-protocol violation
wr_drop  out  1  one-cycle pulse: host write rejected

Behaviour:
- Reset (synchronous, active-high; clock = clock):
  - All outputs go to 0 and the state goes to IDLE.
  - Operand buffer is cleared to 0. idx, partial, prod_q and prod_v are cleared.
  - Reset in any state, including mid-RUN, aborts the run with no result update.
- State IDLE:
  - idx (which drives entry_count) = 0, partial = 0, prod_v = 0.
  - If multiply_matrix && load_matrix: issue entry 0 this cycle and go to RUN.
- Issue step (IDLE start cycle and RUN cycles with multiply_matrix && load_matrix && !issued_all):
  - prod_q <= A[idx]*B[idx], prod_v <= 1.
  - If idx == 7, set issued_all; otherwise idx <= idx+1.
  - idx saturates at 7, so entry 7 is issued exactly once.
- Accumulate step (every cycle in RUN): if prod_v, partial <= partial + prod_q.
- Latency: the product is registered 1 cycle after issue and added to partial the following cycle.
- Controller timing: entry_count reads 0..7 on the 8 multiply cycles; the controller leaves Multiply after seeing 7.
- RUN, multiply held after issued_all: no new issue; prod_v <= 0 once the pending product has been absorbed.
- RUN, add:
  - If issued_all: result <= partial + (prod_v ? prod_q : 0), go to SUM.
  - Otherwise: seq_error <= 1, result unchanged, go to IDLE.
- RUN, multiply_matrix drops with neither issued_all nor add: seq_error <= 1, go to IDLE.
- SUM: wait for done. done -> HOLD with result_valid <= 1. multiply/add in SUM are ignored.
- HOLD:
  - result_valid = 1 while done stays high.
  - When done drops: go to IDLE, result_valid <= 0, result retained.
- done asserted in IDLE or RUN: seq_error <= 1, result_valid stays 0.
- Host writes:
  - Accepted only in IDLE and HOLD.
  - wr_en in RUN/SUM: write is discarded and wr_drop pulses for 1 cycle.
  - A write in the same cycle as the IDLE->RUN start is accepted; entry 0 still uses the old value if wr_addr == 0, because the read precedes the write.
- seq_error clears only on reset.
- Arithmetic: unsigned; product is 2*DATA_W bits, zero-extended into ACC_W. No saturation needed.

Test Plan:
- Write A[i]=i+1, B[i]=1; drive controller sequence (8 multiply cycles, 1 add, done held) -> entry_count 0..7 on successive cycles, result = 36, result_valid=1 in HOLD, busy=1 during run.
- All A=B=255 -> result = 520200 (no overflow); then done drops -> result_valid=0, result still 520200.
- Assert reset at the 4th multiply cycle -> next cycle all outputs 0, state IDLE; a fresh run with A[i]=2, B[i]=3 -> result = 48.
- add asserted after only 5 multiply cycles -> seq_error=1, result=0, state IDLE; seq_error remains 1 through a subsequent good run.
- wr_en with wr_addr=3, wr_a=9 during RUN -> wr_drop=1 for 1 cycle, A[3] unchanged; the same write in HOLD is accepted, and the next run reflects A[3]=9.
- Back-to-back runs (HOLD -> IDLE -> start immediately) -> partial cleared; second result depends only on second-run operands.
